seq_rx_tracker: RTL and testbench

//  Receive-side tracker for the 8-bit wrapping count stream produced by the counter

---
 rtl/seq_rx_pkg.sv | 19 +
 rtl/seq_rx_sat_cnt.sv | 24 ++
 rtl/seq_rx_tracker_sva.sv | 25 ++
 rtl/seq_rx_tracker.sv | 140 ++++++++++++++
 tb/tb_seq_rx_tracker.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_rx_pkg.sv
// Shared types and helpers for the receive-side sequence tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_rx_pkg;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    localparam int STAT_W = 16;

    // Successor in the wrapping count stream; callers truncate to their data width.
    function automatic int succ(input int x, input int wrap_val);
        return (x == wrap_val) ? 0 : x + 1;
    endfunction

endpackage

// File: rtl/seq_rx_sat_cnt.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: 1 cycle from inc/clr to cnt.
// Backpressure: none; one increment per asserted cycle, holds at all-ones.
module seq_rx_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_rx_tracker_sva.sv
// Bind-able protocol checker for seq_rx_tracker pulse/lock outputs.
// Latency: observes registered outputs, one-cycle lookahead.
// Backpressure: n/a (passive).
module seq_rx_tracker_sva #(
    parameter int LOSS_THRESH = 2
) (
    input logic clk,
    input logic rst,
    input logic locked,
    input logic err_pulse,
    input logic wrap_pulse
);

    a_wrap_not_err: assert property (@(posedge clk) disable iff (rst)
        !(wrap_pulse && err_pulse));

    // Two back-to-back locked errors are only impossible when two misses drop lock.
    generate
        if (LOSS_THRESH <= 2) begin : g_err_pair
            a_no_err_pair: assert property (@(posedge clk) disable iff (rst)
                (err_pulse && locked) |=> !(err_pulse && locked));
        end
    endgenerate

endmodule

// File: rtl/seq_rx_tracker.sv
// Tracks a wrapping count stream: hunt, verify, lock and flywheel; flags errors/wraps.
// Latency: 1 cycle, all outputs registered from the previous sample edge.
// Backpressure: in_valid low stalls all state; stats via SEQ_RX_TRACKER_STATS_EN.
module seq_rx_tracker
    import seq_rx_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int WRAP_VAL    = 128,
    parameter int LOCK_THRESH = 4,
    parameter int LOSS_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              stats_clr,
    output logic              locked,
    output logic              err_pulse,
    output logic              wrap_pulse,
    output logic [STAT_W-1:0] err_count,
    output logic [STAT_W-1:0] wrap_count
);

    localparam int GW = $clog2(LOCK_THRESH + 1);
    localparam int BW = $clog2(LOSS_THRESH + 1);
    localparam logic [WIDTH-1:0] WRAP_V = WIDTH'(WRAP_VAL);
    localparam logic [GW-1:0]    LOCK_V = GW'(LOCK_THRESH);
    localparam logic [BW-1:0]    LOSS_V = BW'(LOSS_THRESH);

    state_t           state;
    logic [WIDTH-1:0] exp_val;
    logic [GW-1:0]    good_cnt;
    logic [BW-1:0]    bad_cnt;

    logic             legal;
    logic             match;
    logic [WIDTH-1:0] data_succ;
    logic [WIDTH-1:0] exp_succ;
    logic [GW-1:0]    good_inc;
    logic [BW-1:0]    bad_inc;
    logic             err_nxt;
    logic             wrap_nxt;

    always_comb begin
        legal     = (in_data <= WRAP_V);
        match     = (in_data == exp_val);
        data_succ = WIDTH'(succ(int'(in_data), WRAP_VAL));
        exp_succ  = WIDTH'(succ(int'(exp_val), WRAP_VAL));
        good_inc  = good_cnt + 1'b1;
        bad_inc   = bad_cnt + 1'b1;
        err_nxt   = in_valid && (state == LOCKED) && !match;
        // While locked exp only ever advances by succ, so exp==0 implies the prior exp was WRAP_VAL.
        wrap_nxt  = in_valid && (state == LOCKED) && match && (exp_val == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            exp_val    <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            err_pulse  <= err_nxt;
            wrap_pulse <= wrap_nxt;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (legal) begin
                            exp_val  <= data_succ;
                            good_cnt <= GW'(1);
                            state    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (!legal) begin
                            good_cnt <= '0;
                            state    <= HUNT;
                        end else if (match) begin
                            exp_val  <= data_succ;
                            good_cnt <= good_inc;
                            if (good_inc == LOCK_V) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                bad_cnt <= '0;
                            end
                        end else begin
                            exp_val  <= data_succ;
                            good_cnt <= GW'(1);
                        end
                    end
                    LOCKED: begin
                        exp_val <= exp_succ;
                        if (match) begin
                            bad_cnt <= '0;
                        end else if (bad_inc == LOSS_V) begin
                            state    <= HUNT;
                            locked   <= 1'b0;
                            bad_cnt  <= '0;
                            good_cnt <= '0;
                        end else begin
                            bad_cnt <= bad_inc;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SEQ_RX_TRACKER_STATS_EN
    // Counters take the same-edge pulse decision so a count lands with its pulse.
    seq_rx_sat_cnt #(.WIDTH(STAT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_nxt),
        .clr (stats_clr),
        .cnt (err_count)
    );

    seq_rx_sat_cnt #(.WIDTH(STAT_W)) u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .inc (wrap_nxt),
        .clr (stats_clr),
        .cnt (wrap_count)
    );
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign err_count        = '0;
    assign wrap_count       = '0;
`endif

endmodule

// File: tb/tb_seq_rx_tracker.sv
// Directed plus randomized bench for seq_rx_tracker against a run-length reference model.
module tb_seq_rx_tracker;

    localparam int WRAP  = 128;
    localparam int LOCKN = 4;
    localparam int LOSSN = 2;
`ifdef SEQ_RX_TRACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        stats_clr = 1'b0;
    logic        locked, err_pulse, wrap_pulse;
    logic [15:0] err_count, wrap_count;

    logic        sc_inc = 1'b0;
    logic        sc_clr = 1'b0;
    logic [3:0]  sc_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_rx_tracker #(.WIDTH(8), .WRAP_VAL(WRAP), .LOCK_THRESH(LOCKN), .LOSS_THRESH(LOSSN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .stats_clr(stats_clr),
        .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
        .err_count(err_count), .wrap_count(wrap_count)
    );

    seq_rx_tracker_sva #(.LOSS_THRESH(LOSSN)) u_sva (
        .clk(clk), .rst(rst), .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse)
    );

    seq_rx_sat_cnt #(.WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .inc(sc_inc), .clr(sc_clr), .cnt(sc_cnt)
    );

    // Reference model: lock = run of LOCKN consecutive successors; locked expectation
    // is anchor + samples-since-lock modulo (WRAP+1).
    bit m_locked;
    int m_run, m_last, m_anchor, m_k, m_miss;
    bit m_err, m_wrap;
    int m_errc, m_wrapc;

    function automatic void model_reset();
        m_locked = 0; m_run = 0; m_last = 0; m_anchor = 0; m_k = 0; m_miss = 0;
        m_err = 0; m_wrap = 0; m_errc = 0; m_wrapc = 0;
    endfunction

    function automatic void model_step(input bit v, input int s, input bit clr);
        int e;
        m_err = 0;
        m_wrap = 0;
        if (v) begin
            if (!m_locked) begin
                if (s > WRAP) m_run = 0;
                else if (m_run > 0 && s == (m_last + 1) % (WRAP + 1)) m_run++;
                else m_run = 1;
                m_last = s;
                if (m_run >= LOCKN) begin
                    m_locked = 1; m_anchor = s; m_k = 0; m_miss = 0;
                end
            end else begin
                m_k++;
                e = (m_anchor + m_k) % (WRAP + 1);
                if (s == e) begin
                    m_miss = 0;
                    m_wrap = (e == 0);
                end else begin
                    m_err = 1;
                    m_miss++;
                    if (m_miss >= LOSSN) begin
                        m_locked = 0; m_run = 0;
                    end
                end
            end
        end
        if (STATS) begin
            if (clr) begin
                m_errc = 0; m_wrapc = 0;
            end else begin
                if (m_err && m_errc < 65535) m_errc++;
                if (m_wrap && m_wrapc < 65535) m_wrapc++;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_model();
        check("locked", {15'd0, locked}, 16'(m_locked));
        check("err_pulse", {15'd0, err_pulse}, 16'(m_err));
        check("wrap_pulse", {15'd0, wrap_pulse}, 16'(m_wrap));
        check("err_count", err_count, 16'(m_errc));
        check("wrap_count", wrap_count, 16'(m_wrapc));
    endtask

    task automatic step(input bit v, input int d, input bit c);
        in_valid  = v;
        in_data   = d[7:0];
        stats_clr = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        in_valid = 0; stats_clr = 0; rst = 1;
        @(posedge clk);
        #1;
        model_reset();
        check_model();
        rst = 0;
    endtask

    initial begin
        int seqv[5];
        int nwrap;
        int cur;
        int r;

        // Reset state and basic lock on 0..3
        do_reset();
        check("rst_locked", {15'd0, locked}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, i, 0);
            check("prelock", {15'd0, locked}, 16'd0);
        end
        step(1, 3, 0);
        check("lock_after_3", {15'd0, locked}, 16'd1);

        // Wrap through WRAP_VAL -> 0
        do_reset();
        for (int i = 122; i < 126; i++) step(1, i, 0);
        seqv = '{126, 127, 128, 0, 1};
        nwrap = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, seqv[i], 0);
            nwrap += int'(wrap_pulse);
            check("wrap_no_err", {15'd0, err_pulse}, 16'd0);
            if (i == 3) check("wrap_after_0", {15'd0, wrap_pulse}, 16'd1);
        end
        check("wrap_once", 16'(nwrap), 16'd1);

        // Single error keeps lock
        do_reset();
        for (int i = 6; i < 10; i++) step(1, i, 0);
        step(1, 10, 0);
        step(1, 50, 0);
        check("single_err", {15'd0, err_pulse}, 16'd1);
        check("single_err_locked", {15'd0, locked}, 16'd1);
        step(1, 12, 0);
        check("flywheel_match", {15'd0, err_pulse}, 16'd0);
        check("flywheel_locked", {15'd0, locked}, 16'd1);

        // Two errors drop lock, then relock
        do_reset();
        for (int i = 6; i < 10; i++) step(1, i, 0);
        step(1, 10, 0);
        step(1, 99, 0);
        check("loss_err1", {15'd0, err_pulse}, 16'd1);
        step(1, 99, 0);
        check("loss_err2", {15'd0, err_pulse}, 16'd1);
        check("loss_unlocked", {15'd0, locked}, 16'd0);
        for (int i = 5; i < 9; i++) step(1, i, 0);
        check("relock", {15'd0, locked}, 16'd1);

        // Illegal value in HUNT, then lock with valid gaps
        do_reset();
        step(1, 200, 0);
        check("illegal_hunt", {15'd0, locked}, 16'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, i, 0);
            if (i < 3) for (int g = 0; g < 3; g++) step(0, 77, 0);
        end
        check("gap_lock", {15'd0, locked}, 16'd1);

        // Stats: three errors, clear colliding with an error, reset while locked
        do_reset();
        for (int i = 0; i < 4; i++) step(1, i, 0);
        step(1, 99, 0); step(1, 5, 0);
        step(1, 99, 0); step(1, 7, 0);
        step(1, 99, 0); step(1, 9, 0);
        check("err_count_3", err_count, STATS ? 16'd3 : 16'd0);
        step(1, 99, 1);
        check("clr_wins", err_count, 16'd0);
        check("clr_err_pulse", {15'd0, err_pulse}, 16'd1);
        rst = 1;
        #1;
        model_reset();
        check("rst_mid_locked", {15'd0, locked}, 16'd0);
        check_model();
        @(negedge clk);
        rst = 0;

        // Saturating counter boundary: holds at all-ones, clear beats increment
        sc_inc = 1;
        repeat (20) @(posedge clk);
        #1;
        check("sat_hold", {12'd0, sc_cnt}, 16'd15);
        sc_clr = 1;
        @(posedge clk);
        #1;
        check("sat_clr_prio", {12'd0, sc_cnt}, 16'd0);
        sc_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("sat_count3", {12'd0, sc_cnt}, 16'd3);
        sc_inc = 0;

        // Randomized stream: mostly in-sequence with stalls, corruption, jumps, clears
        do_reset();
        cur = $urandom_range(WRAP);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(99);
            if ($urandom_range(599) == 0) begin
                do_reset();
            end else if (r < 12) begin
                step(0, $urandom_range(255), $urandom_range(19) == 0);
            end else if (r < 20) begin
                step(1, $urandom_range(255), $urandom_range(19) == 0);
                cur = (cur + 1) % (WRAP + 1);
            end else begin
                if (r < 22) cur = $urandom_range(WRAP);
                step(1, cur, $urandom_range(19) == 0);
                cur = (cur + 1) % (WRAP + 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
